map_updater: RTL and testbench

MAP_UPDATER -- requirements
Module: map_updater

---
 rtl/map_updater_pkg.sv | 27 ++
 rtl/map_updater_pix2tile.sv | 20 ++
 rtl/map_updater.sv | 114 +++++++++++
 tb/tb_map_updater.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/map_updater_pkg.sv
// map_updater_pkg: tile codes, map geometry and FSM encoding shared by the map updater
package map_updater_pkg;

  // Tile codes stored in the map RAM
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BRICK = 2'b01,
    STEEL = 2'b10,
    WATER = 2'b11
  } tile_t;

  // Controller states
  typedef enum logic [2:0] {
    IDLE,
    LD_RD,
    LD_WR,
    HIT_RD,
    HIT_CHK
  } state_t;

  // Map geometry in tiles and pixels
  localparam int TILE_PX  = 40;
  localparam int MAP_W    = 16;
  localparam int MAP_H    = 12;
  localparam int MAP_LAST = 191;

endpackage

// File: rtl/map_updater_pix2tile.sv
// pix2tile: converts an impact pixel into a map tile address plus an out-of-range flag
module pix2tile
  import map_updater_pkg::*;
(
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  output logic [10:0] addr,
  output logic        out_of_range
);

  logic [3:0] tx;
  logic [3:0] ty;

  assign out_of_range = (x >= 10'(MAP_W * TILE_PX)) || (y >= 9'(MAP_H * TILE_PX));
  // Division by a constant; the quotient only matters when in range, where it fits in 4 bits
  assign tx = 4'(x / 10'(TILE_PX));
  assign ty = 4'(y / 9'(TILE_PX));
  assign addr = out_of_range ? '0 : 11'(ty * MAP_W + tx);

endmodule

// File: rtl/map_updater.sv
// map_updater: loads the tile map from the level ROM and resolves bullet impacts against it
module map_updater
  import map_updater_pkg::*;
(
  input  logic        clk25,
  input  logic        reset,
  input  logic        load_start,
  output logic [7:0]  level_addr,
  input  logic [1:0]  level_data,
  input  logic        hit_valid,
  output logic        hit_ready,
  input  logic [9:0]  hit_x,
  input  logic [8:0]  hit_y,
  output logic        hit_done,
  output logic [1:0]  hit_result,
  output logic [10:0] map_raddr,
  input  logic [1:0]  map_rdata,
  output logic [10:0] write,
  output logic        we,
  output logic [1:0]  data,
  output logic        load_done,
  output logic        busy
);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [9:0]  hx;
  logic [8:0]  hy;
  logic [10:0] addr;
  logic        oor;
  logic        last;
  logic        accept;

  // Address is derived from the registered impact point so it is stable through HIT_RD/HIT_CHK
  pix2tile u_pix2tile (
    .x            (hx),
    .y            (hy),
    .addr         (addr),
    .out_of_range (oor)
  );

  assign last   = cnt == 8'(MAP_LAST);
  assign accept = hit_valid && hit_ready;

  // State register
  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Tile counter for loads and capture of the accepted impact point
  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      hx  <= '0;
      hy  <= '0;
    end else begin
      if (state == IDLE && load_start) cnt <= '0;
      else if (state == LD_WR && !last) cnt <= cnt + 8'd1;
      if (accept) begin
        hx <= hit_x;
        hy <= hit_y;
      end
    end
  end

  // Next state and outputs; a load request takes priority over a hit in IDLE
  always_comb begin
    state_nxt  = state;
    hit_ready  = 1'b0;
    level_addr = '0;
    we         = 1'b0;
    write      = '0;
    data       = '0;
    hit_done   = 1'b0;
    hit_result = '0;
    map_raddr  = '0;
    load_done  = 1'b0;
    busy       = state != IDLE;
    case (state)
      IDLE: begin
        hit_ready = reset && !load_start;
        state_nxt = load_start ? LD_RD : (hit_valid ? HIT_RD : IDLE);
      end
      LD_RD: begin
        level_addr = cnt;
        state_nxt  = LD_WR;
      end
      LD_WR: begin
        level_addr = cnt;
        we         = 1'b1;
        write      = {3'b000, cnt};
        data       = level_data;
        load_done  = last;
        state_nxt  = last ? IDLE : LD_RD;
      end
      HIT_RD: begin
        map_raddr = oor ? '0 : addr;
        state_nxt = HIT_CHK;
      end
      HIT_CHK: begin
        hit_done   = 1'b1;
        hit_result = oor ? STEEL : map_rdata;
        we         = !oor && (map_rdata == BRICK);
        write      = we ? addr : '0;
        data       = EMPTY;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_map_updater.sv
// tb_map_updater: scoreboard bench for map_updater with ROM and map RAM models
`timescale 1ns/1ps
module tb_map_updater;

  logic        clk25 = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic [7:0]  level_addr;
  logic [1:0]  level_data = '0;
  logic        hit_valid = 1'b0;
  logic        hit_ready;
  logic [9:0]  hit_x = '0;
  logic [8:0]  hit_y = '0;
  logic        hit_done;
  logic [1:0]  hit_result;
  logic [10:0] map_raddr;
  logic [1:0]  map_rdata = '0;
  logic [10:0] write;
  logic        we;
  logic [1:0]  data;
  logic        load_done;
  logic        busy;

  logic        poke = 1'b0;
  logic [10:0] poke_a = '0;
  logic [1:0]  poke_d = '0;
  logic [1:0]  mem [0:2047];

  typedef struct packed {logic [10:0] a; logic [1:0] d;} wr_t;
  wr_t        exp_wr[$];
  logic [1:0] exp_hit[$];
  wr_t        w;
  logic [1:0] h;
  int n_chk = 0;
  int n_fail = 0;
  int ld_cnt = 0;

  always #20 clk25 = ~clk25;

  map_updater dut (
    .clk25      (clk25),
    .reset      (reset),
    .load_start (load_start),
    .level_addr (level_addr),
    .level_data (level_data),
    .hit_valid  (hit_valid),
    .hit_ready  (hit_ready),
    .hit_x      (hit_x),
    .hit_y      (hit_y),
    .hit_done   (hit_done),
    .hit_result (hit_result),
    .map_raddr  (map_raddr),
    .map_rdata  (map_rdata),
    .write      (write),
    .we         (we),
    .data       (data),
    .load_done  (load_done),
    .busy       (busy)
  );

  // Level ROM returns addr mod 4 one cycle later; map RAM with registered read
  always @(posedge clk25) begin
    level_data <= level_addr[1:0];
    if (we) mem[write] <= data;
    if (poke) mem[poke_a] <= poke_d;
    map_rdata <= mem[map_raddr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Monitor: every map write and every hit_done is matched against the scoreboard
  always @(negedge clk25) begin
    if (we) begin
      if (exp_wr.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected no write at %0t", write, data, $time);
      end else begin
        w = exp_wr.pop_front();
        chk("write_addr", 32'(write), 32'(w.a));
        chk("write_data", 32'(data), 32'(w.d));
      end
    end
    if (hit_done) begin
      if (exp_hit.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_hit_done: got result %0d expected no hit_done at %0t", hit_result, $time);
      end else begin
        h = exp_hit.pop_front();
        chk("hit_result", 32'(hit_result), 32'(h));
      end
    end
    if (load_done) ld_cnt++;
  end

  task automatic cyc();
    @(posedge clk25);
    #1;
  endtask

  task automatic push_load();
    for (int i = 0; i < 192; i++) exp_wr.push_back({11'(i), 2'(i % 4)});
  endtask

  task automatic wait_load_done();
    int n = 1;
    while (!load_done && n < 500) begin
      cyc();
      n++;
    end
    chk("load_done_cycle", n, 384);
  endtask

  task automatic run_load();
    push_load();
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    chk("load_first_addr", 32'(level_addr), 0);
    chk("load_busy", 32'(busy), 1);
    chk("load_hit_ready", 32'(hit_ready), 0);
    wait_load_done();
    cyc();
    chk("load_idle_ready", 32'(hit_ready), 1);
  endtask

  task automatic do_hit(input logic [9:0] x, input logic [8:0] y, input logic [10:0] ra,
                        input logic [1:0] res, input logic wr);
    chk("hit_ready_idle", 32'(hit_ready), 1);
    exp_hit.push_back(res);
    if (wr) exp_wr.push_back({ra, 2'b00});
    hit_valid = 1'b1;
    hit_x = x;
    hit_y = y;
    cyc();
    hit_valid = 1'b0;
    chk("hit_raddr_t1", 32'(map_raddr), 32'(ra));
    chk("hit_busy_t1", 32'(busy), 1);
    cyc();
    chk("hit_done_t2", 32'(hit_done), 1);
    cyc();
    chk("hit_ready_t3", 32'(hit_ready), 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_we"}, 32'(we), 0);
    chk({nm, "_ready"}, 32'(hit_ready), 0);
    chk({nm, "_done"}, 32'(hit_done), 0);
    chk({nm, "_ldone"}, 32'(load_done), 0);
    chk({nm, "_laddr"}, 32'(level_addr), 0);
    chk({nm, "_write"}, 32'(write), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ld_before;
    cyc();
    chk_zero("reset");
    cyc();
    reset = 1'b1;
    #1;
    chk("ready_after_reset", 32'(hit_ready), 1);
    cyc();
    // Full load, then hits against the loaded map (tile 33 holds 33 mod 4 = BRICK)
    run_load();
    do_hit(10'd45, 9'd85, 11'd33, 2'b01, 1'b1);
    poke = 1'b1;
    poke_a = 11'd33;
    poke_d = 2'b10;
    cyc();
    poke = 1'b0;
    cyc();
    do_hit(10'd45, 9'd85, 11'd33, 2'b10, 1'b0);
    do_hit(10'd640, 9'd0, 11'd0, 2'b10, 1'b0);
    do_hit(10'd639, 9'd479, 11'd191, 2'b11, 1'b0);
    // Reset in the middle of a load
    push_load();
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    n = 0;
    while (!(busy && !we && level_addr == 8'd100) && n < 1000) begin
      cyc();
      n++;
    end
    chk("reached_cnt100", 32'(level_addr), 100);
    ld_before = ld_cnt;
    reset = 1'b0;
    #1;
    chk_zero("midload");
    chk("aborted_writes_left", exp_wr.size(), 92);
    exp_wr.delete();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    chk("no_load_done_abort", ld_cnt, ld_before);
    run_load();
    // load_start and hit_valid together: load wins, hit accepted after load_done
    push_load();
    exp_hit.push_back(2'b01);
    exp_wr.push_back({11'd33, 2'b00});
    load_start = 1'b1;
    hit_valid = 1'b1;
    hit_x = 10'd45;
    hit_y = 9'd85;
    #1;
    chk("collision_ready", 32'(hit_ready), 0);
    cyc();
    load_start = 1'b0;
    chk("collision_busy", 32'(busy), 1);
    wait_load_done();
    cyc();
    chk("collision_ready_after", 32'(hit_ready), 1);
    cyc();
    hit_valid = 1'b0;
    chk("collision_raddr", 32'(map_raddr), 33);
    cyc();
    chk("collision_hit_done", 32'(hit_done), 1);
    cyc();
    cyc();
    chk("wr_queue_left", exp_wr.size(), 0);
    chk("hit_queue_left", exp_hit.size(), 0);
    chk("load_done_total", ld_cnt, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
